// File: rtl/eth_axis_rx_dest_filter.sv
// Destination-MAC filter for the byte-wide receive AXI stream.
// Buffers the 6-byte header, decides per frame, then replays or discards.
module eth_axis_rx_dest_filter #(
    parameter bit ACCEPT_BROADCAST = 1'b1,
    parameter bit ACCEPT_MULTICAST = 1'b1,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic [47:0]            local_mac,
    input  logic                   promisc_en,
    output logic                   stat_frame_pass,
    output logic                   stat_frame_drop,
    output logic [COUNT_WIDTH-1:0] stat_drop_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_REPLAY = 3'd2;
    localparam logic [2:0] S_PASS   = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [5:0][7:0]        hdr_q, hdr_d;
    logic [2:0]             pos_q, pos_d;
    logic [47:0]            mac_q, mac_d;
    logic                   promisc_q, promisc_d;
    logic                   run_q;
    logic                   pass_q, pass_d;
    logic                   drop_q, drop_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic        s_hs;
    logic        m_hs;
    logic        drop_evt;
    logic [47:0] dest_w;
    logic        match_w;

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    assign stat_frame_pass = pass_q;
    assign stat_frame_drop = drop_q;
    assign stat_drop_count = cnt_q;

    // Destination match, using the 6th byte straight off the bus.
    always_comb begin
        dest_w  = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], s_axis_tdata};
        match_w = promisc_q
                | (dest_w == mac_q)
                | (ACCEPT_BROADCAST && (&dest_w))
                | (ACCEPT_MULTICAST && hdr_q[0][0]);
    end

    // Stream outputs per state; run_q holds tready low until out of reset.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        unique case (state_q)
            S_IDLE, S_HDR, S_DROP: begin
                s_axis_tready = run_q;
            end
            S_REPLAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_q[pos_q];
            end
            S_PASS: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = s_axis_tlast;
                m_axis_tuser  = s_axis_tuser;
            end
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

    // Frame FSM, header capture and drop statistics.
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        pos_d     = pos_q;
        mac_d     = mac_q;
        promisc_d = promisc_q;
        pass_d    = 1'b0;
        drop_evt  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (s_hs) begin
                    hdr_d[0]  = s_axis_tdata;
                    mac_d     = local_mac;
                    promisc_d = promisc_en;
                    if (s_axis_tlast) begin
                        drop_evt = 1'b1;
                    end else begin
                        pos_d   = 3'd1;
                        state_d = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (s_hs) begin
                    hdr_d[pos_q] = s_axis_tdata;
                    if (s_axis_tlast) begin
                        drop_evt = 1'b1;
                        state_d  = S_IDLE;
                    end else if (pos_q == 3'd5) begin
                        pos_d   = 3'd0;
                        state_d = match_w ? S_REPLAY : S_DROP;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
            end
            S_REPLAY: begin
                if (m_hs) begin
                    if (pos_q == 3'd5) begin
                        pos_d   = 3'd0;
                        state_d = S_PASS;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
            end
            S_PASS: begin
                if (s_hs && s_axis_tlast) begin
                    pass_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (s_hs && s_axis_tlast) begin
                    drop_evt = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        drop_d = drop_evt;
        cnt_d  = cnt_q;
        if (drop_evt && (cnt_q != {COUNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hdr_q     <= '0;
            pos_q     <= 3'd0;
            mac_q     <= 48'h0;
            promisc_q <= 1'b0;
            run_q     <= 1'b0;
            pass_q    <= 1'b0;
            drop_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            pos_q     <= pos_d;
            mac_q     <= mac_d;
            promisc_q <= promisc_d;
            run_q     <= 1'b1;
            pass_q    <= pass_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule
